// File: rtl/window_pkg.sv
// window_pkg: shared FSM encoding and window-geometry constants for window_ctrl7.
//   No ports. Provides state_t, WIN_DEFAULT and win_off() (window centre offset).
package window_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    localparam int WIN_DEFAULT = 7;
    function automatic int win_off(input int w);
        return (w - 1) / 2;
    endfunction
endpackage

// File: rtl/pos_counter.sv
// pos_counter: column/row position counter with frame wrap and last-pixel flag.
//   clk, rst      : clock, asynchronous active-low reset
//   en            : advance past the pixel being accepted
//   start         : the pixel being accepted is (0,0)
//   col, row      : position of the next pixel to be accepted
//   pix_col/row   : position of the pixel being accepted this cycle
//   last          : pixel being accepted is the last pixel of the frame
module pos_counter #(
    parameter int W = 640,
    parameter int H = 480,
    localparam int CW = $clog2(W),
    localparam int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] pix_col,
    output logic [RW-1:0] pix_row,
    output logic          last
);
    logic col_end, row_end;
    assign pix_col = start ? '0 : col;
    assign pix_row = start ? '0 : row;
    assign col_end = pix_col == CW'(W - 1);
    assign row_end = pix_row == RW'(H - 1);
    assign last    = col_end && row_end;
    // the row also wraps after the last pixel so the counter never leaves the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            col <= col_end ? '0 : pix_col + 1'b1;
            row <= col_end ? (row_end ? '0 : pix_row + 1'b1) : pix_row;
        end
    end
endmodule

// File: rtl/window_ctrl7.sv
// window_ctrl7: frame/window sequencing for a WINxWIN sliding-window row-buffer chain.
//   clk, rst           : clock, asynchronous active-low reset
//   s_valid/s_sof/s_data/s_ready : upstream pixel stream
//   m_ready            : window consumer can accept a window
//   buf_en/buf_din     : shift enable and pixel to the row-buffer chain
//   win_valid/win_col/win_row    : registered window-complete flag and centre position
//   frame_done, err_sync         : one-cycle status pulses
import window_pkg::*;
module window_ctrl7 #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int WIN          = WIN_DEFAULT,
    localparam int CW = $clog2(IMAGE_WIDTH),
    localparam int RW = $clog2(IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic                  s_sof,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  m_ready,
    output logic                  buf_en,
    output logic [DATA_WIDTH-1:0] buf_din,
    output logic                  win_valid,
    output logic [CW-1:0]         win_col,
    output logic [RW-1:0]         win_row,
    output logic                  frame_done,
    output logic                  err_sync
);
    localparam logic [CW-1:0] C_MIN = CW'(WIN - 1);
    localparam logic [RW-1:0] R_MIN = RW'(WIN - 1);
    localparam logic [CW-1:0] C_OFF = CW'(win_off(WIN));
    localparam logic [RW-1:0] R_OFF = RW'(win_off(WIN));
    state_t        state;
    logic [CW-1:0] col, pix_col;
    logic [RW-1:0] row, pix_row;
    logic          last, win_hit;
    // IDLE swallows pixels but only shifts the start-of-frame pixel into the chain
    assign s_ready = (state == IDLE) || (state == ACTIVE && m_ready);
    assign buf_en  = s_valid && (state == IDLE ? s_sof : state == ACTIVE && m_ready);
    assign buf_din = s_data;
    assign win_hit = buf_en && pix_col >= C_MIN && pix_row >= R_MIN;
    pos_counter #(.W(IMAGE_WIDTH), .H(IMAGE_HEIGHT)) u_pos (
        .clk     (clk),
        .rst     (rst),
        .en      (buf_en),
        .start   (s_sof),
        .col     (col),
        .row     (row),
        .pix_col (pix_col),
        .pix_row (pix_row),
        .last    (last)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            state      <= (buf_en && last) ? DONE : buf_en ? ACTIVE : (state == DONE) ? IDLE : state;
            frame_done <= buf_en && last;
            // a resync sof restarts the counters; only flag it when not already at (0,0)
            err_sync   <= buf_en && state == ACTIVE && s_sof && (col != '0 || row != '0);
            win_valid  <= win_hit;
            if (win_hit) begin
                win_col <= pix_col - C_OFF;
                win_row <= pix_row - R_OFF;
            end
        end
    end
endmodule

// File: tb/tb_window_ctrl7.sv
// tb_window_ctrl7: self-checking bench for window_ctrl7 at 16x10 with a 7x7 window.
module tb_window_ctrl7;
    localparam int W = 16, H = 10, WN = 7, OFF = 3;
    logic       clk = 1'b0, rst = 1'b0;
    logic       s_valid = 1'b0, s_sof = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready, buf_en, win_valid, frame_done, err_sync;
    logic [7:0] buf_din;
    logic [3:0] win_col, win_row;
    int checks = 0, errors = 0;
    int m_st = 0, mc = 0, mrow = 0, lc = 0, lr = 0, fc = 0, fr = 0;
    int win_cnt = 0, err_cnt = 0, done_cnt = 0;
    logic acc, exp_win, exp_done, exp_err;
    int qc[$], qr[$];

    window_ctrl7 #(.DATA_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WIN(WN)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
        .s_ready(s_ready), .m_ready(m_ready), .buf_en(buf_en), .buf_din(buf_din),
        .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
        .frame_done(frame_done), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: drive, check combinational outputs, then check registered outputs after the edge
    task automatic step(input logic v, input logic sof, input logic [7:0] d, input logic mrdy);
        logic rdy, en, lst;
        int pc, pr;
        s_valid = v; s_sof = sof; s_data = d; m_ready = mrdy;
        rdy = (m_st == 0) ? 1'b1 : (m_st == 1) ? mrdy : 1'b0;
        en  = v && ((m_st == 0) ? sof : (m_st == 1) ? mrdy : 1'b0);
        acc = en; exp_win = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        #1;
        chk("s_ready", s_ready, rdy);
        chk("buf_en", buf_en, en);
        if (en) begin
            chk("buf_din", buf_din, d);
            pc = sof ? 0 : mc;
            pr = sof ? 0 : mrow;
            exp_err = (m_st == 1) && sof && (mc != 0 || mrow != 0);
            if (pc >= WN - 1 && pr >= WN - 1) begin
                exp_win = 1'b1;
                qc.push_back(pc - OFF);
                qr.push_back(pr - OFF);
            end
            lst = (pc == W - 1) && (pr == H - 1);
            exp_done = lst;
            mc   = (pc == W - 1) ? 0 : pc + 1;
            mrow = (pc == W - 1) ? ((pr == H - 1) ? 0 : pr + 1) : pr;
            m_st = lst ? 2 : 1;
        end else if (m_st == 2) m_st = 0;
        @(posedge clk); #1;
        chk("win_valid", win_valid, exp_win);
        chk("frame_done", frame_done, exp_done);
        chk("err_sync", err_sync, exp_err);
        if (err_sync) err_cnt++;
        if (frame_done) done_cnt++;
        if (win_valid) begin
            chk("win_queue", qc.size() > 0, 1);
            if (qc.size() > 0) begin
                lc = qc.pop_front();
                lr = qr.pop_front();
                if (win_cnt == 0) begin fc = lc; fr = lr; end
            end
            win_cnt++;
        end
        chk("win_col", win_col, lc);
        chk("win_row", win_row, lr);
    endtask

    task automatic send_frame(input int npix, input bit tog, input int exp_w, input string tag);
        int p = 0, guard = 0;
        win_cnt = 0; done_cnt = 0;
        while (p < npix && guard < 2000) begin
            step(1'b1, p == 0, 8'(p * 7 + 3), tog ? 1'(guard % 2) : 1'b1);
            if (acc) p++;
            guard++;
        end
        chk({tag, "_pixels"}, p, npix);
        if (npix == W * H) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk({tag, "_done_pulses"}, done_cnt, 1);
        end
        chk({tag, "_windows"}, win_cnt, exp_w);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_buf_en", buf_en, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_sync", err_sync, 0);
        rst = 1'b1;
        // pixels without sof in IDLE are dropped
        win_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h50 + i), 1'b1);
        chk("idle_windows", win_cnt, 0);
        // full frame, consumer always ready
        send_frame(W * H, 1'b0, 40, "full");
        chk("full_first_col", fc, 3);
        chk("full_first_row", fr, 3);
        chk("full_last_col", lc, 12);
        chk("full_last_row", lr, 6);
        // consumer toggling every cycle
        send_frame(W * H, 1'b1, 40, "toggle");
        chk("toggle_first_col", fc, 3);
        chk("toggle_last_col", lc, 12);
        // unexpected sof at pixel (5,8)
        send_frame(8 * W + 5, 1'b0, 20, "pre_err");
        err_cnt = 0;
        send_frame(W * H, 1'b0, 40, "post_err");
        chk("err_pulses", err_cnt, 1);
        chk("post_err_first_col", fc, 3);
        chk("post_err_first_row", fr, 3);
        // reset while pixel (10,7) is presented
        send_frame(7 * W + 10, 1'b0, 14, "pre_rst");
        s_valid = 1'b1; s_sof = 1'b0; s_data = 8'hAA; m_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_buf_en", buf_en, 0);
        chk("mid_rst_win_valid", win_valid, 0);
        chk("mid_rst_win_col", win_col, 0);
        chk("mid_rst_win_row", win_row, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_err_sync", err_sync, 0);
        m_st = 0; mc = 0; mrow = 0; lc = 0; lr = 0;
        qc.delete(); qr.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        win_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b1);
        chk("post_rst_idle_windows", win_cnt, 0);
        send_frame(W * H, 1'b0, 40, "post_rst");
        chk("post_rst_first_col", fc, 3);
        chk("post_rst_last_row", lr, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
